// File: rtl/if_stage_if.sv
// if_stage_if: decode-side and instruction-memory-side signals of the fetch stage.
// master = fetch stage, slave = decode/memory environment.
interface if_stage_if;
  logic        stall;
  logic        jump_taken;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  modport master (
    input  stall, jump_taken, jump_addr, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, inst, inst_addr, inst_valid
  );
  modport slave (
    output stall, jump_taken, jump_addr, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, inst, inst_addr, inst_valid
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: PC owner issuing in-order imem fetches into a prefetch buffer, one inst/cycle to decode.
// Define IF_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0] ah_q, ah_d, at_q, at_d, bh_q, bh_d, bt_q, bt_d;
  logic [31:0] addr_fifo [FIFO_DEPTH];
  logic [31:0] buf_inst [FIFO_DEPTH];
  logic [31:0] buf_addr [FIFO_DEPTH];
  logic [31:0] inst_q, inst_d, inst_addr_q, inst_addr_d;
  logic        valid_q, valid_d;
  logic        req, accept, rsp, keep, redir, push, pop, byp;
  logic [31:0] rsp_pc4;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + PW'(1);
  endfunction
  assign req     = !rst && (out_q + cnt_q) < CW'(FIFO_DEPTH);
  assign accept  = req && bus.imem_gnt;
  assign rsp     = bus.imem_rvalid && out_q != '0;
  assign keep    = rsp && drop_q == '0;
  assign redir   = bus.jump_taken && !bus.stall;
  assign rsp_pc4 = addr_fifo[ah_q] + 32'd4;
`ifdef IF_BYPASS_EN
  assign byp = keep && cnt_q == '0 && !bus.stall && !redir;
`else
  assign byp = 1'b0;
`endif
  assign push = keep && !redir && !byp;
  assign pop  = !bus.stall && !redir && cnt_q != '0;
  always_comb begin
    pc_d        = redir ? bus.jump_addr : accept ? pc_q + 32'd4 : pc_q;
    out_d       = out_q + CW'(accept) - CW'(rsp);
    // a redirect kills every fetch still in flight, including one granted this cycle
    drop_d      = redir ? out_q - CW'(rsp) + CW'(accept) : drop_q - CW'(rsp && drop_q != '0);
    cnt_d       = redir ? '0 : cnt_q + CW'(push) - CW'(pop);
    at_d        = accept ? inc(at_q) : at_q;
    ah_d        = rsp ? inc(ah_q) : ah_q;
    bt_d        = redir ? '0 : push ? inc(bt_q) : bt_q;
    bh_d        = redir ? '0 : pop ? inc(bh_q) : bh_q;
    inst_d      = bus.stall ? inst_q : byp ? bus.imem_rdata : pop ? buf_inst[bh_q] : 32'h0;
    inst_addr_d = bus.stall ? inst_addr_q : byp ? rsp_pc4 : pop ? buf_addr[bh_q] : inst_addr_q;
    valid_d     = bus.stall ? valid_q : byp || pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      cnt_q       <= '0;
      ah_q        <= '0;
      at_q        <= '0;
      bh_q        <= '0;
      bt_q        <= '0;
      inst_q      <= 32'h0;
      inst_addr_q <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      ah_q        <= ah_d;
      at_q        <= at_d;
      bh_q        <= bh_d;
      bt_q        <= bt_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      valid_q     <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) addr_fifo[at_q] <= pc_q;
    if (push) begin
      buf_inst[bt_q] <= bus.imem_rdata;
      buf_addr[bt_q] <= rsp_pc4;
    end
  end
  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_addr  = inst_addr_q;
  assign bus.inst_valid = valid_q;
  assert property (@(posedge clk) disable iff (rst) !(bus.imem_rvalid && out_q == '0));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + randomized fetch traffic; a scoreboard of expected decode words
// is filled from a program-order PC model and drained by an independent monitor.
`timescale 1ns/1ps
module tb_if_stage;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0;
`ifdef IF_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  if_stage_if bus();
  if_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_fail = 0, n_deliv = 0, gnt_pct = 100, rv_pct = 100;
  logic [63:0] sb[$];
  logic [31:0] pending[$];
  logic [31:0] model_pc = RPC;
  logic        o_req, o_valid, o_acc;
  logic [31:0] o_addr, o_inst, o_iaddr;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock: drive memory, observe at negedge, advance the reference model after the edge
  task automatic cycle();
    logic rv, redir;
    bus.imem_gnt    = int'($urandom_range(0, 99)) < gnt_pct;
    rv              = !rst && pending.size() != 0 && int'($urandom_range(0, 99)) < rv_pct;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? pending[0] : 32'hDEAD_BEEF;
    @(negedge clk);
    o_req   = bus.imem_req;
    o_addr  = bus.imem_addr;
    o_valid = bus.inst_valid;
    o_inst  = bus.inst;
    o_iaddr = bus.inst_addr;
    o_acc   = o_req && bus.imem_gnt;
    redir   = bus.jump_taken && !bus.stall && !rst;
    if (rst) chk("req_in_reset", 32'(o_req), 32'd0);
    else if (o_req) chk("imem_addr", o_addr, model_pc);
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      pending.delete();
      model_pc = RPC;
    end else begin
      if (rv) void'(pending.pop_front());
      if (o_acc) pending.push_back(o_addr);
      if (redir) begin
        sb.delete();
        model_pc = bus.jump_addr;
      end else if (o_acc) begin
        sb.push_back({model_pc, model_pc + 32'd4});
        model_pc += 32'd4;
      end
    end
  endtask
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && !bus.stall && bus.inst_valid) begin
      n_deliv++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_inst: got %h/%h expected none at %0t", bus.inst, bus.inst_addr, $time);
      end else begin
        e = sb.pop_front();
        chk("inst", bus.inst, e[63:32]);
        chk("inst_addr", bus.inst_addr, e[31:0]);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g, v, d;
    logic [31:0] fi, fa, a0;
    bus.stall = 0; bus.jump_taken = 0; bus.jump_addr = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    repeat (2) cycle();
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_addr", bus.inst_addr, 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    rst = 0;
    g = -1; v = -1;
    for (int i = 0; i < 20 && v < 0; i++) begin
      cycle();
      if (g < 0 && o_acc) g = i;
      if (v < 0 && o_valid) v = i;
    end
    chk("first_grant_cycle", g, 0);
    chk("first_valid_latency", v - g, LAT);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("steady_valid", 32'(o_valid), 32'd1);
    end
    bus.stall = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin fi = o_inst; fa = o_iaddr; end
      chk("stall_valid_held", 32'(o_valid), 32'd1);
      if (i > 0) begin
        chk("stall_inst_frozen", o_inst, fi);
        chk("stall_addr_frozen", o_iaddr, fa);
      end
      if (i >= 3) chk("stall_full_req", 32'(o_req), 32'd0);
    end
    bus.stall = 0;
    d = n_deliv;
    repeat (8) cycle();
    chk("drain_after_stall", 32'(n_deliv - d >= 5), 32'd1);
    rst = 1; cycle(); rst = 0;
    gnt_pct = 100; rv_pct = 0;
    repeat (2) cycle();
    chk("outstanding_before_jump", pending.size(), 2);
    bus.jump_taken = 1; bus.jump_addr = 32'h100;
    cycle();
    chk("grant_with_jump", 32'(o_acc), 32'd1);
    bus.jump_taken = 0;
    rv_pct = 100;
    v = -1;
    for (int i = 0; i < 20 && v < 0; i++) begin
      cycle();
      if (o_valid) begin v = i; chk("jump_first_addr", o_iaddr, 32'h104); chk("jump_first_inst", o_inst, 32'h100); end
    end
    chk("jump_target_seen", 32'(v >= 0), 32'd1);
    gnt_pct = 0;
    repeat (4) cycle();
    bus.stall = 1; bus.jump_taken = 1; bus.jump_addr = 32'h200;
    cycle();
    a0 = o_addr;
    bus.stall = 0;
    cycle();
    chk("stalled_jump_ignored", o_addr, a0);
    bus.jump_taken = 0;
    cycle();
    chk("jump_after_stall", o_addr, 32'h200);
    repeat (4) cycle();
    gnt_pct = 100; rv_pct = 0;
    repeat (2) cycle();
    chk("outstanding_before_rst", pending.size(), 2);
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin
        chk("post_rst_addr", o_addr, RPC);
        chk("post_rst_valid", 32'(o_valid), 32'd0);
      end
      chk("post_rst_credit", 32'(o_req), 32'(i < DEPTH));
    end
    gnt_pct = 60; rv_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      bus.stall      = $urandom_range(0, 4) == 0;
      bus.jump_taken = $urandom_range(0, 19) == 0;
      bus.jump_addr  = $urandom & 32'h0000_FFFC;
      cycle();
    end
    bus.stall = 0; bus.jump_taken = 0;
    gnt_pct = 0; rv_pct = 100;
    repeat (30) cycle();
    chk("sb_drained", sb.size(), 0);
    chk("mem_drained", pending.size(), 0);
    chk("random_progress", 32'(n_deliv > 200), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
